// File: rtl/simon_pkg.sv
// Shared Simon definitions: autoplayer state encoding, LED helpers and memory depth.
package simon_pkg;

    localparam int unsigned MEM_DEPTH = 10;

    typedef enum logic [1:0] {
        ST_CAPTURE  = 2'd0,
        ST_PRESS    = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_LOW = 2'd3
    } autoplayer_state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder.
module decoder_2_4 (
    input  logic [1:0] idx,
    output logic [3:0] onehot_c
);

    assign onehot_c = 4'b0001 << idx;

endmodule

// File: rtl/simon_autoplayer.sv
// Records the Simon LED blink sequence and replays it on the switches once the game accepts input.
// Optional feature macro: SIMON_AUTOPLAYER_MISTAKE_EN (corrupts the last replayed colour on request).
module simon_autoplayer
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN      = MEM_DEPTH,
    parameter int unsigned PRESS_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [3:0]                   led_in,
    input  logic                         accept_in,
    input  logic                         inject_err,
    output logic [3:0]                   sw_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         bad_led,
    output logic                         overflow
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W   = $clog2(MAX_LEN);
    localparam int unsigned CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    autoplayer_state_t state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        sw_out_q, sw_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bad_led_q, bad_led_d;
    logic              overflow_q, overflow_d;
    logic [3:0]        led_prev_q;
    logic [1:0]        mem_q [MAX_LEN];

    logic              wr_en_c;
    logic [LEN_W-1:0]  rd_nxt_c;
    logic [1:0]        mem_rd_c;
    logic [1:0]        sel_idx_c;
    logic [3:0]        press_pat_c;

    // Element about to be pressed: the first on replay start, otherwise the next one.
    assign rd_nxt_c = (state_q == ST_CAPTURE) ? '0 : rd_q + LEN_W'(1);
    assign mem_rd_c = (rd_nxt_c < LEN_W'(MAX_LEN)) ? mem_q[IDX_W'(rd_nxt_c)] : 2'd0;

`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
    logic err_q, err_d;
    logic err_now_c;

    // On replay start the request is taken straight from the input so a 1-element replay sees it.
    assign err_now_c = (state_q == ST_CAPTURE) ? inject_err : err_q;
    assign sel_idx_c = (err_now_c && (rd_nxt_c == len_q - LEN_W'(1))) ? mem_rd_c + 2'd1 : mem_rd_c;
`else
    logic unused_inject_err;

    assign unused_inject_err = inject_err;
    assign sel_idx_c         = mem_rd_c;
`endif

    decoder_2_4 u_dec (
        .idx      (sel_idx_c),
        .onehot_c (press_pat_c)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        sw_out_d   = sw_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bad_led_d  = bad_led_q;
        overflow_d = overflow_q;
        wr_en_c    = 1'b0;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            ST_CAPTURE: begin
                if (accept_in) begin
                    if (len_q != '0) begin
                        state_d  = ST_PRESS;
                        rd_d     = '0;
                        cnt_d    = '0;
                        sw_out_d = press_pat_c;
                        busy_d   = 1'b1;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
                        err_d    = inject_err;
`endif
                    end else begin
                        state_d = ST_WAIT_LOW;
                        done_d  = 1'b1;
                        len_d   = '0;
                    end
                end else if (is_onehot(led_in)) begin
                    if (led_prev_q == 4'd0) begin
                        if (len_q == LEN_W'(MAX_LEN)) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en_c = 1'b1;
                            len_d   = len_q + LEN_W'(1);
                        end
                    end
                end else if (led_in != 4'd0) begin
                    bad_led_d = 1'b1;
                end
            end
            ST_PRESS, ST_GAP: begin
                if (!accept_in) begin
                    // Game left the accept phase early: drop everything without a done pulse.
                    state_d  = ST_CAPTURE;
                    sw_out_d = 4'd0;
                    busy_d   = 1'b0;
                    len_d    = '0;
                    cnt_d    = '0;
                end else if (state_q == ST_PRESS) begin
                    if (cnt_q == CNT_W'(PRESS_CYCLES - 1)) begin
                        state_d  = ST_GAP;
                        cnt_d    = '0;
                        sw_out_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (rd_q < len_q - LEN_W'(1)) begin
                        state_d  = ST_PRESS;
                        rd_d     = rd_nxt_c;
                        sw_out_d = press_pat_c;
                    end else begin
                        state_d = ST_WAIT_LOW;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        len_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (!accept_in) state_d = ST_CAPTURE;
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CAPTURE;
            len_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            sw_out_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bad_led_q  <= 1'b0;
            overflow_q <= 1'b0;
            led_prev_q <= 4'd0;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            sw_out_q   <= sw_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bad_led_q  <= bad_led_d;
            overflow_q <= overflow_d;
            led_prev_q <= led_in;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
            err_q      <= err_d;
`endif
        end
    end

    // Colour storage, written only on a capture event.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MAX_LEN); i++) mem_q[i] <= 2'd0;
        end else if (wr_en_c) begin
            mem_q[IDX_W'(len_q)] <= onehot_to_idx(led_in);
        end
    end

    assign sw_out   = sw_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign len      = len_q;
    assign bad_led  = bad_led_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Self-checking bench for simon_autoplayer: directed and random capture/replay against a queue-based model.
module tb_simon_autoplayer;

    localparam int unsigned MAX_LEN = 10;
    localparam int unsigned P       = 2;
    localparam int unsigned G       = 2;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       led_in;
    logic             accept_in;
    logic             inject_err;
    logic [3:0]       sw_out;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] len;
    logic             bad_led;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    logic [3:0] model_q[$];
    bit         model_over = 1'b0;
    bit         model_bad  = 1'b0;

    simon_autoplayer #(
        .MAX_LEN      (MAX_LEN),
        .PRESS_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .led_in     (led_in),
        .accept_in  (accept_in),
        .inject_err (inject_err),
        .sw_out     (sw_out),
        .busy       (busy),
        .done       (done),
        .len        (len),
        .bad_led    (bad_led),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next colour in the game's cyclic order.
    function automatic logic [3:0] next_colour(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // One blink starting just after a falling edge; the model records what a player should remember.
    task automatic blink(input logic [3:0] c, input int hold, input int gap);
        led_in = c;
        repeat (hold) @(negedge clk);
        led_in = 4'd0;
        repeat (gap) @(negedge clk);
        if ($countones(c) == 1) begin
            if (model_q.size() < MAX_LEN) model_q.push_back(c);
            else model_over = 1'b1;
        end else if (c != 4'd0) begin
            model_bad = 1'b1;
        end
    endtask

    task automatic replay(input bit inj, input int abort_at);
        logic [3:0] exp_sw[$];
        logic [3:0] v;
        int         n;
        int         total;
        bit         inj_eff;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
        inj_eff = inj;
`else
        inj_eff = 1'b0;
`endif
        n     = model_q.size();
        total = n * int'(P + G);
        for (int e = 0; e < n; e++) begin
            v = model_q[e];
            if (inj_eff && e == n - 1) v = next_colour(v);
            repeat (P) exp_sw.push_back(v);
            repeat (G) exp_sw.push_back(4'd0);
        end
        accept_in  = 1'b1;
        inject_err = inj;
        if (n == 0) begin
            @(negedge clk);
            check("empty_done", 32'(done), 32'd1);
            check("empty_busy", 32'(busy), 32'd0);
            check("empty_sw", 32'(sw_out), 32'd0);
            @(negedge clk);
            check("empty_done_once", 32'(done), 32'd0);
            check("empty_busy2", 32'(busy), 32'd0);
            accept_in = 1'b0;
            @(negedge clk);
            return;
        end
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            check($sformatf("sw_c%0d", c), 32'(sw_out), 32'(exp_sw[c]));
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            inject_err = 1'($urandom);
            if (c == abort_at) begin
                accept_in = 1'b0;
                led_in    = 4'd0;
                model_q.delete();
                @(negedge clk);
                check("abort_sw", 32'(sw_out), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_len", 32'(len), 32'd0);
                @(negedge clk);
                check("abort_no_done", 32'(done), 32'd0);
                return;
            end
            // LED noise while replaying must be ignored.
            led_in = (c < total - 1) ? 4'($urandom) : 4'd0;
        end
        @(negedge clk);
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_sw", 32'(sw_out), 32'd0);
        check("end_len", 32'(len), 32'd0);
        led_in = 4'b0010;
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        led_in = 4'd0;
        @(negedge clk);
        accept_in  = 1'b0;
        inject_err = 1'b0;
        @(negedge clk);
        check("wait_low_len", 32'(len), 32'd0);
        model_q.delete();
    endtask

    initial begin
        int n;
        int total;
        int abort_at;

        rst        = 1'b1;
        led_in     = 4'd0;
        accept_in  = 1'b0;
        inject_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sw", 32'(sw_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_len", 32'(len), 32'd0);
        check("rst_bad", 32'(bad_led), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed capture of 4,1,1,8 and full replay.
        blink(4'd4, 3, 2);
        blink(4'd1, 3, 2);
        blink(4'd1, 3, 2);
        blink(4'd8, 3, 2);
        check("cap_len4", 32'(len), 32'(model_q.size()));
        replay(1'b0, -1);

        // Empty replay.
        replay(1'b0, -1);

        // Abort during the second press of a 3-element replay.
        blink(4'd2, 2, 1);
        blink(4'd8, 1, 1);
        blink(4'd1, 4, 3);
        check("cap_len3", 32'(len), 32'd3);
        replay(1'b0, int'(P + G));

        // Random rounds.
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < n; i++)
                blink(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(1, 3));
            check("rand_len", 32'(len), 32'(model_q.size()));
            total    = n * int'(P + G);
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
            replay(1'($urandom), abort_at);
        end
        check("no_bad_yet", 32'(bad_led), 32'(model_bad));
        check("no_ovf_yet", 32'(overflow), 32'(model_over));

        // Overflow and malformed LED.
        for (int i = 0; i < 11; i++) blink(4'(1 << $urandom_range(0, 3)), 2, 1);
        blink(4'b0110, 2, 1);
        check("ovf_len", 32'(len), 32'd10);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("bad_flag", 32'(bad_led), 32'd1);
        replay(1'b0, -1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("bad_sticky", 32'(bad_led), 32'd1);

`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
        blink(4'd2, 3, 2);
        blink(4'd8, 3, 2);
        replay(1'b1, -1);
`endif

        // Asynchronous reset in the middle of a replay.
        blink(4'd1, 2, 1);
        blink(4'd4, 2, 1);
        accept_in = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_sw", 32'(sw_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_len", 32'(len), 32'd0);
        check("arst_bad", 32'(bad_led), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        accept_in = 1'b0;
        rst       = 1'b0;
        model_q.delete();
        @(negedge clk);
        check("post_rst_len", 32'(len), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
